// File: rtl/xevious_pkg.sv
// Shared types and widths for the Xevious coin conditioner.
package xevious_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_t;

    localparam int CNT_W  = 4;
    localparam int PEND_W = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;

    // Saturating increment of the queued-credit counter.
    function automatic logic [PEND_W-1:0] pend_inc(input logic [PEND_W-1:0] p);
        return (p == PEND_MAX) ? p : p + 2'd1;
    endfunction

endpackage

// File: rtl/xevious_coin_chan.sv
// One coin channel: IDLE/PULSE/GAP sequencer with a frame counter and a credit queue.
module xevious_coin_chan
    import xevious_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_GAP    = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic frame_tick,
    input  logic req_rise,
    output logic coin_out,
    output logic coin_busy
);

    localparam logic [CNT_W-1:0] FRAMES_LAST = CNT_W'(COIN_FRAMES);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(COIN_GAP);

    coin_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PEND_W-1:0]  pend_reg, pend_next;
    logic [CNT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_reg + 4'd1;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_rise) begin
                    state_next = ST_PULSE;
                    cnt_next   = '0;
                end
            end
            ST_PULSE: begin
                if (req_rise)
                    pend_next = pend_inc(pend_reg);
                if (frame_tick) begin
                    if (cnt_inc == FRAMES_LAST) begin
                        state_next = ST_GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            ST_GAP: begin
                if (frame_tick && (cnt_inc == GAP_LAST)) begin
                    cnt_next = '0;
                    // A fresh edge on the exit cycle cancels the dequeue of a stored credit.
                    if (pend_reg != '0) begin
                        state_next = ST_PULSE;
                        if (!req_rise)
                            pend_next = pend_reg - 2'd1;
                    end else if (req_rise) begin
                        state_next = ST_PULSE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (frame_tick)
                        cnt_next = cnt_inc;
                    if (req_rise)
                        pend_next = pend_inc(pend_reg);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                pend_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
        end
    end

    assign coin_out  = (state_reg == ST_PULSE);
    assign coin_busy = (state_reg != ST_IDLE) | (pend_reg != '0);

endmodule

// File: rtl/xevious_coin_cond.sv
// Coin/service input conditioner: synchronises raw requests, derives frame ticks
// from vblank and shapes each coin request into frame-timed credit pulses.
module xevious_coin_cond
    import xevious_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_GAP    = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       vblank,
    input  logic       pause,
    input  logic [1:0] coin_req,
    input  logic       service_sw,
    output logic [1:0] coin_out,
    output logic [1:0] coin_busy,
    output logic       service_trigger
);

    logic [2:0] raw_in;
    logic [2:0] sync1_reg, sync2_reg, edge_reg, armed_reg;
    logic [1:0] valid_reg;
    logic [2:0] rise;
    logic       vb_d1_reg, vb_d2_reg;
    logic       svc_reg;
    logic       frame_tick;

    assign raw_in = {service_sw, coin_req};

    // armed_reg blocks an edge until a genuine low has been seen after reset, so an
    // input already held through reset cannot create a credit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            edge_reg  <= '0;
            armed_reg <= '0;
            valid_reg <= '0;
            vb_d1_reg <= 1'b0;
            vb_d2_reg <= 1'b0;
            svc_reg   <= 1'b0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
            edge_reg  <= sync2_reg;
            valid_reg <= {valid_reg[0], 1'b1};
            armed_reg <= armed_reg | (~sync2_reg & {3{valid_reg[1]}});
            vb_d1_reg <= vblank;
            vb_d2_reg <= vb_d1_reg;
            svc_reg   <= rise[2];
        end
    end

    assign rise            = sync2_reg & ~edge_reg & armed_reg;
    assign frame_tick      = vb_d1_reg & ~vb_d2_reg & ~pause;
    assign service_trigger = svc_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            xevious_coin_chan #(
                .COIN_FRAMES (COIN_FRAMES),
                .COIN_GAP    (COIN_GAP)
            ) u_chan (
                .clk_sys    (clk_sys),
                .reset      (reset),
                .frame_tick (frame_tick),
                .req_rise   (rise[gi]),
                .coin_out   (coin_out[gi]),
                .coin_busy  (coin_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_xevious_coin_cond.sv
// Directed table-driven bench for xevious_coin_cond plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_xevious_coin_cond;

    logic       clk_sys;
    logic       reset;
    logic       vblank;
    logic       pause;
    logic [1:0] coin_req;
    logic       service_sw;
    logic [1:0] coin_out;
    logic [1:0] coin_busy;
    logic       service_trigger;

    int checks = 0;
    int errors = 0;

    xevious_coin_cond dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .vblank          (vblank),
        .pause           (pause),
        .coin_req        (coin_req),
        .service_sw      (service_sw),
        .coin_out        (coin_out),
        .coin_busy       (coin_busy),
        .service_trigger (service_trigger)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       pause;
        logic [1:0] req;
        logic       svc;
        int         frames;
        int         cyc;
        logic [1:0] exp_out;
        logic [1:0] exp_busy;
        logic       exp_svc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic p, input logic [1:0] r, input logic s,
                                input int f, input int c, input logic [1:0] eo,
                                input logic [1:0] eb, input logic es);
        vec_t v;
        v.pause = p; v.req = r; v.svc = s; v.frames = f; v.cyc = c;
        v.exp_out = eo; v.exp_busy = eb; v.exp_svc = es;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One video frame: 100 cycles, vblank high for the first 10.
    task automatic run_frame();
        vblank = 1'b1;
        repeat (10) @(negedge clk_sys);
        vblank = 1'b0;
        repeat (90) @(negedge clk_sys);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    task automatic press0();
        coin_req[0] = 1'b1;
        repeat (3) @(negedge clk_sys);
        coin_req[0] = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        reset = 1'b1; vblank = 1'b0; pause = 1'b0; coin_req = 2'b00; service_sw = 1'b0;
        repeat (4) @(negedge clk_sys);
        reset = 1'b0;

        // reset state
        add(0, 2'b00, 0, 0, 3, 2'b00, 2'b00, 0);
        // service trigger latency
        add(0, 2'b00, 1, 0, 2, 2'b00, 2'b00, 0);
        add(0, 2'b00, 1, 0, 1, 2'b00, 2'b00, 1);
        add(0, 2'b00, 1, 0, 1, 2'b00, 2'b00, 0);
        add(0, 2'b00, 0, 0, 3, 2'b00, 2'b00, 0);
        // single coin1 press: latency 3, 4 frames high, 4 frames gap
        add(0, 2'b01, 0, 0, 2, 2'b00, 2'b00, 0);
        add(0, 2'b01, 0, 0, 1, 2'b01, 2'b01, 0);
        add(0, 2'b00, 0, 3, 0, 2'b01, 2'b01, 0);
        add(0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0);
        add(0, 2'b00, 0, 3, 0, 2'b00, 2'b01, 0);
        add(0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0);
        // both channels at once
        add(0, 2'b11, 0, 0, 3, 2'b11, 2'b11, 0);
        add(0, 2'b00, 0, 4, 0, 2'b00, 2'b11, 0);
        add(0, 2'b00, 0, 4, 0, 2'b00, 2'b00, 0);
        // coin2 alone
        add(0, 2'b10, 0, 0, 3, 2'b10, 2'b10, 0);
        add(0, 2'b00, 0, 8, 0, 2'b00, 2'b00, 0);
        // held request gives one credit only
        add(0, 2'b01, 0, 0, 3, 2'b01, 2'b01, 0);
        add(0, 2'b01, 0, 4, 0, 2'b00, 2'b01, 0);
        add(0, 2'b01, 0, 4, 0, 2'b00, 2'b00, 0);
        add(0, 2'b00, 0, 0, 3, 2'b00, 2'b00, 0);
        // pause for 10 frames mid-pulse, press queued during pause
        add(0, 2'b01, 0, 0, 3, 2'b01, 2'b01, 0);
        add(0, 2'b00, 0, 2, 0, 2'b01, 2'b01, 0);
        add(1, 2'b00, 0, 10, 0, 2'b01, 2'b01, 0);
        add(1, 2'b01, 0, 0, 3, 2'b01, 2'b01, 0);
        add(1, 2'b00, 0, 0, 3, 2'b01, 2'b01, 0);
        add(0, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0);
        add(0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0);
        add(0, 2'b00, 0, 3, 0, 2'b00, 2'b01, 0);
        add(0, 2'b00, 0, 1, 0, 2'b01, 2'b01, 0);
        add(0, 2'b00, 0, 4, 0, 2'b00, 2'b01, 0);
        add(0, 2'b00, 0, 4, 0, 2'b00, 2'b00, 0);

        foreach (vecs[i]) begin
            pause = vecs[i].pause;
            coin_req = vecs[i].req;
            service_sw = vecs[i].svc;
            run_frames(vecs[i].frames);
            repeat (vecs[i].cyc) @(negedge clk_sys);
            $display("vec %0d: out=%b busy=%b svc=%b", i, coin_out, coin_busy, service_trigger);
            chk($sformatf("vec%0d_out", i), 32'(coin_out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_busy", i), 32'(coin_busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_svc", i), 32'(service_trigger), 32'(vecs[i].exp_svc));
        end
        pause = 1'b0; coin_req = 2'b00; service_sw = 1'b0;
        repeat (3) @(negedge clk_sys);

        // five presses in one pulse: pending saturates, four pulses of 4 frames, 4-frame gaps
        begin
            int pulses;
            int run;
            logic prev;
            logic cur;
            for (int k = 0; k < 5; k++) press0();
            chk("sat_start", 32'(coin_out[0]), 32'd1);
            prev = coin_out[0];
            pulses = prev ? 1 : 0;
            run = 1;
            for (int f = 0; f < 36; f++) begin
                run_frame();
                cur = coin_out[0];
                if (cur == prev) begin
                    run++;
                end else begin
                    if (prev) chk("sat_high_len", 32'(run), 32'd4);
                    else      chk("sat_gap_len", 32'(run), 32'd4);
                    if (cur) pulses++;
                    run = 1;
                    prev = cur;
                end
            end
            $display("saturation: pulses=%0d busy=%b", pulses, coin_busy[0]);
            chk("sat_pulses", 32'(pulses), 32'd4);
            chk("sat_busy_end", 32'(coin_busy[0]), 32'd0);
        end

        // press lands on the exact GAP-exit cycle with nothing queued
        press0();
        run_frames(4);
        chk("gx_in_gap", 32'(coin_out[0]), 32'd0);
        run_frames(3);
        coin_req[0] = 1'b1;
        @(negedge clk_sys);
        chk("gx_busy1", 32'(coin_busy[0]), 32'd1);
        vblank = 1'b1;
        @(negedge clk_sys);
        chk("gx_busy2", 32'(coin_busy[0]), 32'd1);
        chk("gx_still_gap", 32'(coin_out[0]), 32'd0);
        @(negedge clk_sys);
        chk("gx_pulse", 32'(coin_out[0]), 32'd1);
        chk("gx_busy3", 32'(coin_busy[0]), 32'd1);
        repeat (8) @(negedge clk_sys);
        vblank = 1'b0;
        coin_req[0] = 1'b0;
        repeat (90) @(negedge clk_sys);
        run_frames(4);
        chk("gx_gap2", 32'(coin_out[0]), 32'd0);
        run_frames(4);
        $display("gap exit: out=%b busy=%b", coin_out[0], coin_busy[0]);
        chk("gx_no_pending", 32'(coin_busy[0]), 32'd0);

        // reset mid-pulse with two queued credits
        begin
            logic seen;
            press0(); press0(); press0();
            run_frame();
            chk("rst_pre", 32'(coin_out[0]), 32'd1);
            reset = 1'b1;
            @(negedge clk_sys);
            chk("rst_out", 32'(coin_out[0]), 32'd0);
            chk("rst_busy", 32'(coin_busy), 32'd0);
            reset = 1'b0;
            seen = 1'b0;
            for (int f = 0; f < 20; f++) begin
                run_frame();
                if (coin_out != 2'b00) seen = 1'b1;
            end
            $display("reset mid-pulse: later pulse seen=%b", seen);
            chk("rst_no_pulse", 32'(seen), 32'd0);
            chk("rst_busy_end", 32'(coin_busy), 32'd0);
        end

        // request held through reset must not create a credit until re-pressed
        coin_req[0] = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        chk("held_rst_out", 32'(coin_out[0]), 32'd0);
        chk("held_rst_busy", 32'(coin_busy[0]), 32'd0);
        coin_req[0] = 1'b0;
        repeat (3) @(negedge clk_sys);
        coin_req[0] = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("held_repress_lat2", 32'(coin_out[0]), 32'd0);
        @(negedge clk_sys);
        chk("held_repress_lat3", 32'(coin_out[0]), 32'd1);
        coin_req[0] = 1'b0;
        run_frames(8);
        $display("held through reset: busy=%b", coin_busy[0]);
        chk("held_done", 32'(coin_busy[0]), 32'd0);

        // service switch held 1000 cycles while paused
        begin
            int count;
            int first;
            count = 0;
            first = 0;
            pause = 1'b1;
            service_sw = 1'b1;
            for (int i = 1; i <= 1000; i++) begin
                @(negedge clk_sys);
                if (service_trigger) begin
                    count++;
                    if (first == 0) first = i;
                end
            end
            $display("service: pulses=%0d first=%0d", count, first);
            chk("svc_count", 32'(count), 32'd1);
            chk("svc_latency", 32'(first), 32'd3);
            service_sw = 1'b0;
            pause = 1'b0;
        end

        repeat (3) @(negedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xevious_coin_cond.md
XEVIOUS_COIN_COND -- requirements
Module: xevious_coin_cond

Interface
REQ-001 Parameter COIN_FRAMES, default 4, number of frames coin_out stays high per credit; legal range 1..15.
REQ-002 Parameter COIN_GAP, default 4, number of frames coin_out stays low before the next credit; legal range 1..15.
REQ-003 clk_sys  in  1  system clock; the block has one clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vblank  in  1  video vertical blank, clk_sys domain; its rising edge defines a frame.
REQ-006 pause  in  1  CPU pause; high freezes all frame counting.
REQ-007 coin_req  in  2  raw coin requests from joystick/keyboard, asynchronous; bit0 = coin1, bit1 = coin2.
REQ-008 service_sw  in  1  raw service-mode OSD switch, asynchronous.
REQ-009 coin_out  out  2  shaped coin signals, active-high, to the game core coin1/coin2.
REQ-010 coin_busy  out  2  high while the channel is not IDLE or has pending credits.
REQ-011 service_trigger  out  1  single-cycle pulse that feeds the core reset OR.

Function
REQ-012 coin_req and service_sw each pass through a 2-flop synchroniser; a third flop supplies the edge detect.
REQ-013 frame_tick is high for exactly one clk_sys cycle after a registered 0->1 of vblank; it is qualified by ~pause.
REQ-014 Each coin channel has the FSM states IDLE, PULSE and GAP, a 4-bit frame counter and a 2-bit pending counter.
REQ-015 IDLE + rising edge of the synchronised request -> PULSE with counter=0; coin_out rises after the 3rd clk_sys edge that samples coin_req high (latency 3 cycles).
REQ-016 PULSE: the counter increments on each frame_tick; on the tick that reaches COIN_FRAMES, the state goes to GAP, the counter goes to 0, and coin_out falls in the same registered cycle.
REQ-017 GAP: the counter increments on each frame_tick; on the tick that reaches COIN_GAP, if pending>0 the channel decrements pending and goes to PULSE, otherwise it goes to IDLE.
REQ-018 A request edge during PULSE or GAP increments pending; pending saturates at 3 and further edges are dropped.
REQ-019 A request edge in the same cycle as GAP exit with pending=0 goes directly to PULSE; pending stays 0.
REQ-020 A request edge in the same cycle as GAP exit with pending>0 leaves pending unchanged (the increment and decrement cancel), and the state goes to PULSE.
REQ-021 Holding coin_req high yields exactly one credit; a new credit requires a release.
REQ-022 pause high: state, counters and coin_out hold; request edges are still queued per REQ-018.
REQ-023 coin_out is high only in PULSE; coin_busy = (state!=IDLE) | (pending!=0).
REQ-024 service_trigger is high for one cycle after a synchronised rising edge of service_sw; it is not gated by pause; latency is 3 cycles.
REQ-025 Channels are fully independent; simultaneous requests on both channels are each served with no mutual delay.

Reset
REQ-026 reset forces all channels to IDLE, counters and pending to 0, coin_out=0, coin_busy=0, service_trigger=0, and the synchroniser and vblank flops to 0.
REQ-027 reset asserted mid-PULSE drops coin_out on the next clk_sys edge, and any queued credits are discarded.
REQ-028 After reset is released, a request already held high does not create a credit until it is released and pressed again.

Structure
REQ-029 The state enum (IDLE/PULSE/GAP), the counter widths and the saturation limit of 3 are placed in the shared package xevious_pkg.
REQ-030 One sub-module, xevious_coin_chan, implements a single channel's FSM, counter and pending logic; it is instantiated twice.
REQ-031 The synchronisers, vblank edge detect and service logic stay in the top-level xevious_coin_cond.

Verification
REQ-032 Defaults, single coin1 press, vblank period 100 cycles -> coin_out[0] rises 3 cycles after the press, stays high for 4 frame_ticks, then coin_busy[0] falls after 4 more ticks.
REQ-033 Five coin1 presses within one PULSE -> pending saturates at 3, and exactly 4 pulses occur, each separated by a 4-frame gap.
REQ-034 pause held high for 10 frames mid-PULSE -> coin_out[0] stays high for 14 frames in total, and a press during the pause is served afterwards.
REQ-035 Press arriving in the exact GAP-exit cycle with pending=0 -> the channel goes directly to PULSE with no IDLE cycle, and pending=0.
REQ-036 reset pulsed mid-PULSE with pending=2 -> coin_out=0 next cycle, and no further pulses appear.
REQ-037 service_sw 0->1 held for 1000 cycles -> exactly one service_trigger pulse, 3 cycles after the rise, also while pause=1.
